// File: rtl/jk_ctrl_pkg.sv
// Shared state encoding, JK command codes and the expected-q helper for jk_cmd_arbiter.
package jk_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] CMD_HOLD   = 2'b00;
  localparam logic [1:0] CMD_RESET  = 2'b01;
  localparam logic [1:0] CMD_SET    = 2'b10;
  localparam logic [1:0] CMD_TOGGLE = 2'b11;

  function automatic logic jk_expect(input logic [1:0] cmd, input logic q_now);
    logic v;
    case (cmd)
      CMD_HOLD:   v = q_now;
      CMD_RESET:  v = 1'b0;
      CMD_SET:    v = 1'b1;
      default:    v = ~q_now;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after i_ptr, scanning upward with wrap.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_id
);

  logic           w_found;
  logic [IDW-1:0] w_cand;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[IDW-1:0];
  endfunction

  always_comb begin
    o_grant = '0;
    o_id    = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_cand = wrap_add(i_ptr, i);
      if (i_en && !w_found && i_req[w_cand]) begin
        o_grant[w_cand] = 1'b1;
        o_id            = w_cand;
        w_found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jk_cmd_arbiter.sv
// Round-robin owner of a JK flip-flop bank: grant, drive j/k for one edge, read back q, respond.
// JK_CHECK_EN builds the expected-value comparison; without it rsp_ok is tied high.
module jk_cmd_arbiter
  import jk_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int NFF  = 8,
  parameter int IDXW = 3,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [2*NREQ-1:0]    req_cmd,
  input  logic [IDXW*NREQ-1:0] req_idx,
  output logic [NREQ-1:0]      req_ready,
  output logic [NFF-1:0]       j,
  output logic [NFF-1:0]       k,
  input  logic [NFF-1:0]       q,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_q,
  output logic                 rsp_ok
);

  state_t          r_state;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_id;
  logic [IDXW-1:0] r_idx;

  logic [1:0]      w_cmd_arr [NREQ];
  logic [IDXW-1:0] w_idx_arr [NREQ];
  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_id;
  logic [IDW-1:0]  w_next_ptr;
  logic            w_en;
  logic            w_xfer;
  logic [1:0]      w_sel_cmd;
  logic [IDXW-1:0] w_sel_idx;
  logic [NFF-1:0]  w_sel_mask;
  logic            w_chk_q;

  // One-hot select of a bank bit; an out-of-range index yields all zeros.
  function automatic logic [NFF-1:0] bit_at(input logic [IDXW-1:0] ix);
    logic [NFF-1:0] v;
    v = '0;
    for (int b = 0; b < NFF; b++) begin
      if (int'(ix) == b) v[b] = 1'b1;
    end
    return v;
  endfunction

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_cmd_arr[g] = req_cmd[2*g +: 2];
    assign w_idx_arr[g] = req_idx[IDXW*g +: IDXW];
  end

  assign w_en = (r_state == IDLE) && !rst;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .i_en    (w_en),
    .o_grant (w_grant),
    .o_id    (w_id)
  );

  assign req_ready  = w_grant;
  assign w_xfer     = |w_grant;
  assign w_sel_cmd  = w_cmd_arr[w_id];
  assign w_sel_idx  = w_idx_arr[w_id];
  assign w_sel_mask = bit_at(w_sel_idx);
  assign w_chk_q    = |(q & bit_at(r_idx));
  assign w_next_ptr = (w_id == IDW'(NREQ - 1)) ? '0 : w_id + 1'b1;

`ifdef JK_CHECK_EN
  logic r_expect;
  logic w_chk_in_range;
  logic w_sel_q;

  assign w_sel_q        = |(q & w_sel_mask);
  assign w_chk_in_range = |bit_at(r_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_expect <= 1'b0;
      rsp_ok   <= 1'b0;
    end else if (r_state == IDLE && w_xfer) begin
      r_expect <= jk_expect(w_sel_cmd, w_sel_q);
    end else if (r_state == CHECK) begin
      rsp_ok <= w_chk_in_range && (w_chk_q == r_expect);
    end
  end
`else
  assign rsp_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_id      <= '0;
      r_idx     <= '0;
      j         <= '0;
      k         <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_q     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_id     <= w_id;
            r_idx    <= w_sel_idx;
            r_rr_ptr <= w_next_ptr;
            j        <= w_sel_cmd[1] ? w_sel_mask : '0;
            k        <= w_sel_cmd[0] ? w_sel_mask : '0;
            r_state  <= DRIVE;
          end
        end
        DRIVE: begin
          j       <= '0;
          k       <= '0;
          r_state <= CHECK;
        end
        CHECK: begin
          rsp_q     <= w_chk_q;
          rsp_id    <= r_id;
          rsp_valid <= 1'b1;
          r_state   <= RESP;
        end
        RESP: begin
          rsp_valid <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_cmd_arbiter.sv
// Bench for jk_cmd_arbiter: bank model, per-cycle transaction model, directed command vectors.
module tb_jk_cmd_arbiter;
  import jk_ctrl_pkg::*;

  localparam int NREQ = 4;
  localparam int NFF  = 6;
  localparam int IDXW = 3;
  localparam int IDW  = 2;
`ifdef JK_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic                 clk, rst;
  logic [NREQ-1:0]      req_valid;
  logic [2*NREQ-1:0]    req_cmd;
  logic [IDXW*NREQ-1:0] req_idx;
  logic [NREQ-1:0]      req_ready;
  logic [NFF-1:0]       j, k, q;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic                 rsp_q, rsp_ok;

  jk_cmd_arbiter #(.NREQ(NREQ), .NFF(NFF), .IDXW(IDXW), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd(req_cmd), .req_idx(req_idx),
    .req_ready(req_ready), .j(j), .k(k), .q(q), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_q(rsp_q), .rsp_ok(rsp_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External JK bank; stuck0 forces visible q bits low to emulate a broken flop.
  logic [NFF-1:0] bank, stuck0;
  assign q = bank & ~stuck0;
  always @(posedge clk) begin
    for (int b = 0; b < NFF; b++) begin
      case ({j[b], k[b]})
        2'b01:   bank[b] <= 1'b0;
        2'b10:   bank[b] <= 1'b1;
        2'b11:   bank[b] <= ~bank[b];
        default: bank[b] <= bank[b];
      endcase
    end
  end

  int n_chk, n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic jk_truth(input logic q0, input logic [1:0] c);
    if (c == 2'b00) return q0;
    if (c == 2'b01) return 1'b0;
    if (c == 2'b10) return 1'b1;
    return ~q0;
  endfunction

  // Transaction model: m_ph counts cycles since the transfer (0 = idle).
  int m_ph, m_ptr, m_id, m_idx, eid, cidx, cyc;
  logic [1:0] m_cmd;
  logic m_qb, m_qc, exp_ok;
  logic [NREQ-1:0] exp_rdy;
  logic [NFF-1:0] exp_j, exp_k;
  int g_ids[$];
  int g_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      m_ph  = 0;
      m_ptr = 0;
      chk("rst_ready", req_ready, 0);
      chk("rst_j", j, 0);
      chk("rst_k", k, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
    end else begin
      exp_rdy = '0;
      eid = -1;
      if (m_ph == 0) begin
        for (int i = 0; i < NREQ; i++) begin
          cidx = (m_ptr + i) % NREQ;
          if (eid < 0 && req_valid[cidx]) eid = cidx;
        end
      end
      if (eid >= 0) exp_rdy[eid] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);

      exp_j = '0;
      exp_k = '0;
      if (m_ph == 1 && m_idx < NFF) begin
        exp_j[m_idx] = m_cmd[1];
        exp_k[m_idx] = m_cmd[0];
      end
      chk("j_bus", j, exp_j);
      chk("k_bus", k, exp_k);
      chk("rsp_valid", rsp_valid, (m_ph == 3));

      if (m_ph == 3) begin
        exp_ok = CHK ? ((m_idx < NFF) && (m_qc == jk_truth(m_qb, m_cmd))) : 1'b1;
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_q", rsp_q, m_qc);
        chk("rsp_ok", rsp_ok, exp_ok);
      end

      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && req_valid[i]) begin
          g_ids.push_back(i);
          g_cyc.push_back(cyc);
        end
      end

      if (m_ph == 0) begin
        if (eid >= 0) begin
          m_id  = eid;
          m_idx = int'(req_idx[eid*IDXW +: IDXW]);
          m_cmd = req_cmd[eid*2 +: 2];
          m_qb  = (m_idx < NFF) ? q[m_idx] : 1'b0;
          m_ptr = (eid + 1) % NREQ;
          m_ph  = 1;
        end
      end else if (m_ph == 2) begin
        m_qc = (m_idx < NFF) ? (stuck0[m_idx] ? 1'b0 : jk_truth(m_qb, m_cmd)) : 1'b0;
        m_ph = 3;
      end else if (m_ph == 3) begin
        m_ph = 0;
      end else begin
        m_ph = m_ph + 1;
      end
    end
  end

  task automatic issue(input int r, input logic [1:0] c, input int ix,
                       output logic [NFF-1:0] dj, output logic [NFF-1:0] dk,
                       output logic [NREQ-1:0] rdy, output logic [IDW-1:0] id,
                       output logic oq, output logic ok);
    int n;
    @(posedge clk); #1;
    req_cmd[r*2 +: 2]       = c;
    req_idx[r*IDXW +: IDXW] = IDXW'(ix);
    req_valid[r]            = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[r] && n < 20);
    chk("grant_seen", req_ready[r], 1);
    rdy = req_ready;
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    @(negedge clk);
    dj = j;
    dk = k;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 10);
    chk("rsp_seen", rsp_valid, 1);
    id = rsp_id;
    oq = rsp_q;
    ok = rsp_ok;
  endtask

  logic [NFF-1:0]  dj, dk;
  logic [NREQ-1:0] rdy;
  logic [IDW-1:0]  id;
  logic            oq, ok;
  int              exp_order[5] = '{0, 1, 2, 3, 0};
  int              n;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_err = 0; cyc = 0; m_ph = 0; m_ptr = 0;
    rst = 1'b0; req_valid = '0; req_cmd = '0; req_idx = '0;
    bank = '0; stuck0 = '0;
    #1 rst = 1'b1;
    req_valid = '1;
    repeat (2) @(negedge clk);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_q", rsp_q, 0);
    chk("reset_rsp_ok", rsp_ok, CHK ? 0 : 1);
    chk("reset_ready", req_ready, 0);
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk); #2 rst = 1'b0;

    // Single set on idx 3 from requester 0.
    issue(0, CMD_SET, 3, dj, dk, rdy, id, oq, ok);
    chk("t1_ready", rdy, 4'b0001);
    chk("t1_j", dj, 6'b001000);
    chk("t1_k", dk, 6'b000000);
    chk("t1_id", id, 0);
    chk("t1_q", oq, 1);
    chk("t1_ok", ok, 1);

    // Toggle, reset, hold on idx 5 from requesters 1..3 (pointer ends wrapped to 0).
    issue(1, CMD_TOGGLE, 5, dj, dk, rdy, id, oq, ok);
    chk("t2_toggle_q", oq, 1);
    chk("t2_toggle_ok", ok, 1);
    chk("t2_toggle_jk", {dj, dk}, {6'b100000, 6'b100000});
    issue(2, CMD_RESET, 5, dj, dk, rdy, id, oq, ok);
    chk("t2_reset_q", oq, 0);
    chk("t2_reset_ok", ok, 1);
    issue(3, CMD_HOLD, 5, dj, dk, rdy, id, oq, ok);
    chk("t2_hold_q", oq, 0);
    chk("t2_hold_ok", ok, 1);
    chk("t2_hold_j", dj, 0);

    // Fairness with all requesters continuously valid.
    g_ids.delete();
    g_cyc.delete();
    @(posedge clk); #1;
    for (int r = 0; r < NREQ; r++) begin
      req_cmd[r*2 +: 2]       = CMD_HOLD;
      req_idx[r*IDXW +: IDXW] = IDXW'(r);
    end
    req_valid = '1;
    n = 0;
    while (g_ids.size() < 5 && n < 40) begin @(negedge clk); n++; end
    @(posedge clk); #1 req_valid = '0;
    chk("fair_count", g_ids.size(), 5);
    for (int i = 0; i < 5 && i < g_ids.size(); i++) chk("fair_order", g_ids[i], exp_order[i]);
    for (int i = 1; i < 5 && i < g_cyc.size(); i++) chk("fair_gap", g_cyc[i] - g_cyc[i-1], 4);
    repeat (5) @(negedge clk);

    // Stuck-at-0 flop on idx 2.
    @(posedge clk); #1 stuck0[2] = 1'b1;
    issue(1, CMD_SET, 2, dj, dk, rdy, id, oq, ok);
    chk("fault_q", oq, 0);
    chk("fault_ok", ok, CHK ? 0 : 1);
    @(posedge clk); #1 stuck0 = '0;

    // Out-of-range index 7 with a 6-flop bank.
    issue(2, CMD_SET, 7, dj, dk, rdy, id, oq, ok);
    chk("oor_j", dj, 0);
    chk("oor_k", dk, 0);
    chk("oor_id", id, 2);
    chk("oor_q", oq, 0);
    chk("oor_ok", ok, CHK ? 0 : 1);

    // Reset during DRIVE; afterwards arbitration restarts at requester 0.
    @(posedge clk); #1;
    req_cmd[2 +: 2]    = CMD_SET;
    req_idx[IDXW +: IDXW] = 3'd1;
    req_valid[1]       = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[1] && n < 20);
    chk("mid_grant1", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid = 4'b0101;
    req_cmd[0 +: 2] = CMD_HOLD;
    req_cmd[4 +: 2] = CMD_HOLD;
    req_idx[0 +: IDXW] = 3'd0;
    req_idx[2*IDXW +: IDXW] = 3'd4;
    chk("mid_drive_j", j, 6'b000010);
    rst = 1'b1;
    #1;
    chk("mid_async_j", j, 0);
    chk("mid_async_k", k, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (req_ready == '0 && n < 20);
    chk("mid_regrant", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[2] && n < 20);
    chk("mid_next_grant", req_ready, 4'b0100);
    @(posedge clk); #1 req_valid = '0;
    repeat (6) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/jk_cmd_arbiter.md
Name: jk_cmd_arbiter

Overview:
- Round-robin controller that shares one external bank of NFF JK flip-flops among NREQ requesters.
- Each accepted request applies one JK command (hold/reset/set/toggle) to one flip-flop for exactly one clock edge.
- After the edge, the block reads back the flip-flop's q and returns a one-cycle response carrying requester id, q and a pass/fail flag.
- Sits between software-style command sources and the JKFF bank; it is the only driver of the bank's j/k inputs.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NFF, 8, number of JK flip-flops in the controlled bank.
- IDXW, 3, flip-flop index width; must be at least clog2(NFF).
- IDW, 2, requester id width; must be at least clog2(NREQ).

Ports:
- clk  input  1  rising-edge clock, shared with the JKFF bank.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester command valid.
- req_cmd  input  2*NREQ  per-requester command {j,k}, slice r at [2r+1:2r].
- req_idx  input  IDXW*NREQ  per-requester target flip-flop index.
- req_ready  output  NREQ  one-hot grant; a transfer occurs when valid & ready.
- j  output  NFF  J inputs to the bank.
- k  output  NFF  K inputs to the bank.
- q  input  NFF  Q outputs from the bank.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_id  output  IDW  granted requester number.
- rsp_q  output  1  q[idx] sampled in CHECK.
- rsp_ok  output  1  1 = rsp_q matched the expected value.

Behaviour:
- Reset is asynchronous:
  - state=IDLE, rr_ptr=0.
  - j, k, rsp_valid, rsp_id, rsp_q, rsp_ok all 0; req_ready=0.
- Command encoding equals the JK truth table: 00 hold, 01 reset, 10 set, 11 toggle.
- IDLE:
  - req_ready is combinational; exactly one bit is set, for the first valid requester at or after rr_ptr, scanning upward with wrap.
  - req_ready is all-zero outside IDLE or when no request is valid.
  - On transfer, latch cmd, idx and id, and latch expected = q[idx] for hold, 0 for reset, 1 for set, ~q[idx] for toggle.
  - On transfer, set rr_ptr = (id+1) mod NREQ, register j[idx]=cmd[1] and k[idx]=cmd[0] (all other bits 0), then go to DRIVE.
- DRIVE (1 cycle): j/k held; the bank samples them on the edge leaving DRIVE. At that edge j and k clear to all-zero and state goes to CHECK.
- CHECK (1 cycle): capture rsp_q=q[idx] and rsp_ok=(q[idx]==expected); go to RESP.
- RESP (1 cycle): rsp_valid=1 with rsp_id/rsp_q/rsp_ok stable; there is no backpressure. Go to IDLE.
- Outside RESP, rsp_valid=0; rsp_id, rsp_q and rsp_ok hold their last values.
- Latency and throughput:
  - Transfer in cycle T, DRIVE in T+1, CHECK in T+2, rsp_valid in T+3.
  - Next grant is possible in T+4, so at most one command per 4 cycles.
- Boundaries:
  - A requester may drop req_valid before being granted; nothing happens.
  - req_valid changes while not IDLE are ignored.
  - idx >= NFF: no j/k bit is driven, rsp_q=0, and rsp_ok=0.
  - rr_ptr wraps from NREQ-1 to 0.
  - Reset mid-operation aborts immediately: j/k go low asynchronously and no response is issued.
  - Requests still valid after reset are arbitrated from requester 0.

Optional Feature:
- Macro: JK_CHECK_EN.
- Defined: the CHECK comparison is implemented as above.
- Undefined: the expected-value logic is removed and rsp_ok is constant 1. rsp_q is still sampled, and state sequence and latency are unchanged.

Decomposition:
- Package jk_ctrl_pkg holds:
  - the state enum IDLE/DRIVE/CHECK/RESP;
  - the command constants CMD_HOLD=2'b00, CMD_RESET=2'b01, CMD_SET=2'b10, CMD_TOGGLE=2'b11.
- Sub-module rr_arbiter (parameter NREQ):
  - inputs: request vector, pointer, enable;
  - outputs: one-hot grant and encoded id.

Test Plan:
- Reset then single request: rst pulse, then requester 0 sends set on idx 3 with q[3]=0 → req_ready=0001; j[3]=1,k[3]=0 for one cycle only; three cycles after transfer rsp_valid=1, rsp_id=0, rsp_q=1, rsp_ok=1.
- Toggle/reset/hold sequence on idx 5, starting at q=0 → rsp_q values 1, 0, 0, all rsp_ok=1; j/k all-zero between commands.
- Fairness: all 4 requesters valid continuously → grants in order 0,1,2,3,0, one grant every 4 cycles; rr_ptr wraps 3→0.
- Fault detection: the bench forces q[2] to stick at 0 while a set is applied to idx 2 → rsp_q=0, rsp_ok=0 (with JK_CHECK_EN); rsp_ok=1 without the macro.
- Reset mid-operation: assert rst during DRIVE → j/k immediately 0, no rsp_valid; after release, a still-valid requester 2 with requester 0 also valid → grant goes to 0 first.
- Out-of-range index: idx=7 with NFF=6 → j=k=0 throughout, rsp_valid pulse with rsp_ok=0.
